// File: rtl/adc_5g_level_mon.sv
// ADC level monitor: sync-aligned sum-of-squares power and overrange
// counting over 2^ACC_LEN_BITS valid sample cycles, 4-stage datapath.
module adc_5g_level_mon #(
  parameter int ACC_LEN_BITS = 12
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        arm,
  input  logic [7:0]  user_datai0,
  input  logic [7:0]  user_datai1,
  input  logic [7:0]  user_datai2,
  input  logic [7:0]  user_datai3,
  input  logic [7:0]  user_dataq0,
  input  logic [7:0]  user_dataq1,
  input  logic [7:0]  user_dataq2,
  input  logic [7:0]  user_dataq3,
  input  logic        user_outofrange0,
  input  logic        user_outofrange1,
  input  logic        user_sync0,
  input  logic        user_sync1,
  input  logic        user_sync2,
  input  logic        user_sync3,
  input  logic        user_data_valid,
  output logic [47:0] pwr_i,
  output logic [47:0] pwr_q,
  output logic [15:0] ovr_cnt,
  output logic        dump_valid,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    ACC
  } state_t;

  localparam logic [16:0] LEN  = 17'(1) << ACC_LEN_BITS;
  localparam logic [15:0] LAST = 16'(LEN - 17'd1);

  state_t      state;
  state_t      state_nxt;
  logic        take;
  logic        last;
  logic [15:0] cnt;

  logic [7:0]  raw_i [4];
  logic [7:0]  raw_q [4];
  logic        sync_any;
  logic        ovr_any;

  logic signed [7:0] s1_i [4];
  logic signed [7:0] s1_q [4];
  logic              v1, l1, o1;

  logic [14:0] s2_i [4];
  logic [14:0] s2_q [4];
  logic        v2, l2, o2;

  logic [16:0] s3_i;
  logic [16:0] s3_q;
  logic        v3, l3, o3;

  logic [47:0] acc_i;
  logic [47:0] acc_q;
  logic [15:0] acc_o;
  logic [47:0] sum_i;
  logic [47:0] sum_q;
  logic [15:0] sum_o;

  assign raw_i[0] = user_datai0;
  assign raw_i[1] = user_datai1;
  assign raw_i[2] = user_datai2;
  assign raw_i[3] = user_datai3;
  assign raw_q[0] = user_dataq0;
  assign raw_q[1] = user_dataq1;
  assign raw_q[2] = user_dataq2;
  assign raw_q[3] = user_dataq3;

  assign sync_any = user_sync0 | user_sync1 | user_sync2 | user_sync3;
  assign ovr_any  = user_outofrange0 | user_outofrange1;
  assign running  = (state != IDLE);

  function automatic logic [14:0] sq(input logic signed [7:0] x);
    logic signed [15:0] p;
    p = x * x;
    return p[14:0];
  endfunction

  // State register
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state and sample acceptance; arm always wins
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (arm) begin
          state_nxt = WAIT_SYNC;
        end else if (user_data_valid && sync_any) begin
          state_nxt = ACC;
          take      = 1'b1;
        end
      end
      ACC: begin
        if (arm) state_nxt = WAIT_SYNC;
        else     take      = user_data_valid;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = take && (cnt == LAST);

  // Valid-sample counter within the current integration
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset)  cnt <= '0;
    else if (arm)    cnt <= '0;
    else if (take)   cnt <= last ? 16'd0 : cnt + 16'd1;
  end

  // Stage 1: offset binary to two's complement, tags captured
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = 0; k < 4; k++) begin
        s1_i[k] <= '0;
        s1_q[k] <= '0;
      end
      v1 <= 1'b0;
      l1 <= 1'b0;
      o1 <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s1_i[k] <= {~raw_i[k][7], raw_i[k][6:0]};
        s1_q[k] <= {~raw_q[k][7], raw_q[k][6:0]};
      end
      v1 <= take;
      l1 <= last;
      o1 <= ovr_any;
    end
  end

  // Stage 2: squares; arm kills in-flight tags
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = 0; k < 4; k++) begin
        s2_i[k] <= '0;
        s2_q[k] <= '0;
      end
      v2 <= 1'b0;
      l2 <= 1'b0;
      o2 <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s2_i[k] <= sq(s1_i[k]);
        s2_q[k] <= sq(s1_q[k]);
      end
      v2 <= v1 & ~arm;
      l2 <= l1;
      o2 <= o1;
    end
  end

  // Stage 3: per-channel sum of four squares
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      s3_i <= '0;
      s3_q <= '0;
      v3   <= 1'b0;
      l3   <= 1'b0;
      o3   <= 1'b0;
    end else begin
      s3_i <= {2'b0, s2_i[0]} + {2'b0, s2_i[1]}
            + {2'b0, s2_i[2]} + {2'b0, s2_i[3]};
      s3_q <= {2'b0, s2_q[0]} + {2'b0, s2_q[1]}
            + {2'b0, s2_q[2]} + {2'b0, s2_q[3]};
      v3   <= v2 & ~arm;
      l3   <= l2;
      o3   <= o2;
    end
  end

  assign sum_i = acc_i + {31'b0, s3_i};
  assign sum_q = acc_q + {31'b0, s3_q};
  assign sum_o = (o3 && acc_o != 16'hFFFF) ? acc_o + 16'd1 : acc_o;

  // Stage 4: accumulate, dump on the final sample and restart at zero
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      acc_i      <= '0;
      acc_q      <= '0;
      acc_o      <= '0;
      pwr_i      <= '0;
      pwr_q      <= '0;
      ovr_cnt    <= '0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (arm) begin
        acc_i <= '0;
        acc_q <= '0;
        acc_o <= '0;
      end else if (v3) begin
        if (l3) begin
          pwr_i      <= sum_i;
          pwr_q      <= sum_q;
          ovr_cnt    <= sum_o;
          dump_valid <= 1'b1;
          acc_i      <= '0;
          acc_q      <= '0;
          acc_o      <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          acc_o <= sum_o;
        end
      end
    end
  end

endmodule
